// File: rtl/mult_div_unit_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - operation encodings carried on the op port
//   - FSM state encoding
//   - default operand / HI-LO width
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    // Signed variants (MULT, DIV) have op[0] clear.
    function automatic logic mdu_op_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// mdu_sign_fix: combinational conditional two's-complement negate.
// Used as |x| when neg_i is the operand's sign bit, and as the result
// sign correction when neg_i is the expected result sign.
//   val_i [W-1:0]  value to pass through or negate
//   neg_i          1 = negate
//   res_o [W-1:0]  result
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    // Negate or pass through.
    always_comb begin
        if (neg_i) begin
            res_o = ~val_i + {{(W-1){1'b0}}, 1'b1};
        end else begin
            res_o = val_i;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit owning HI/LO.
// Multiply is shift-add on a 2*WIDTH accumulator, divide is restoring
// shift-subtract; both run on operand magnitudes and fix the sign at the end.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op         request pulse and op code (sampled only when idle)
//   reg1, reg2        multiplicand/dividend/MTHI-MTLO source, multiplier/divisor
//   busy, done        operation in flight, one-cycle result-written pulse
//   hi, lo            HI/LO registers
// Build option: MDU_EARLY_TERM_EN lets multiply leave CALC once the
// remaining multiplier bits are all zero (results identical, timing shorter).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_e           state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    // Multiply: acc = partial product, opa = shifting multiplicand, opb = multiplier.
    // Divide:   acc = {remainder, dividend/quotient}, opa[WIDTH-1:0] = divisor.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 busy_q, busy_d, done_q, done_d;

    logic                 op_signed_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0]     a_mag_s, b_mag_s;
    logic [WIDTH:0]       div_shift_s;
    logic                 div_ge_s, div_zero_s;
    logic [WIDTH-1:0]     div_sub_s;
    logic                 calc_last_s, mul_last_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     quot_fix_s, rem_fix_s;

    assign op_signed_s = mdu_op_signed(op);
    assign a_neg_s     = op_signed_s & reg1[WIDTH-1];
    assign b_neg_s     = op_signed_s & reg2[WIDTH-1];

    mdu_sign_fix #(.W(WIDTH))     u_abs_a    (.val_i(reg1),                  .neg_i(a_neg_s),   .res_o(a_mag_s));
    mdu_sign_fix #(.W(WIDTH))     u_abs_b    (.val_i(reg2),                  .neg_i(b_neg_s),   .res_o(b_mag_s));
    mdu_sign_fix #(.W(2*WIDTH))   u_fix_prod (.val_i(acc_q),                 .neg_i(neg_res_q), .res_o(prod_fix_s));
    mdu_sign_fix #(.W(WIDTH))     u_fix_quot (.val_i(acc_q[WIDTH-1:0]),      .neg_i(neg_res_q), .res_o(quot_fix_s));
    mdu_sign_fix #(.W(WIDTH))     u_fix_rem  (.val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .res_o(rem_fix_s));

    // Restoring step: remainder shifted left with the next dividend bit.
    // The subtraction only matters when it does not borrow, so WIDTH bits suffice.
    assign div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, opa_q[WIDTH-1:0]});
    assign div_sub_s   = div_shift_s[WIDTH-1:0] - opa_q[WIDTH-1:0];
    // With a zero divisor every step succeeds: the remainder ends up holding
    // the dividend magnitude, so only the quotient needs forcing.
    assign div_zero_s  = (opa_q[WIDTH-1:0] == {WIDTH{1'b0}});

    assign calc_last_s = (count_q == CNT_W'(WIDTH - 1));
`ifdef MDU_EARLY_TERM_EN
    // Multiplier has no set bits left after this edge's shift.
    assign mul_last_s  = (opb_q[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
    assign mul_last_s  = 1'b0;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            opa_d     = {{WIDTH{1'b0}}, a_mag_s};
                            opb_d     = b_mag_s;
                            acc_d     = {(2*WIDTH){1'b0}};
                            is_div_d  = 1'b0;
                            neg_res_d = a_neg_s ^ b_neg_s;
                            neg_rem_d = 1'b0;
                            count_d   = {CNT_W{1'b0}};
                            busy_d    = 1'b1;
                            state_d   = CALC;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            opa_d     = {{WIDTH{1'b0}}, b_mag_s};
                            opb_d     = {WIDTH{1'b0}};
                            acc_d     = {{WIDTH{1'b0}}, a_mag_s};
                            is_div_d  = 1'b1;
                            neg_res_d = a_neg_s ^ b_neg_s;
                            neg_rem_d = a_neg_s;
                            count_d   = {CNT_W{1'b0}};
                            busy_d    = 1'b1;
                            state_d   = CALC;
                        end
                        MDU_MTHI: hi_d = reg1;
                        MDU_MTLO: lo_d = reg1;
                        default: ;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                count_d = count_q + CNT_W'(1);
                if (is_div_q) begin
                    if (div_ge_s) begin
                        acc_d = {div_sub_s, acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (opb_q[0]) begin
                        acc_d = acc_q + opa_q;
                    end else begin
                        acc_d = acc_q;
                    end
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end
                if (calc_last_s || (!is_div_q && mul_last_s)) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix_s;
                    lo_d = div_zero_s ? {WIDTH{1'b1}} : quot_fix_s;
                end else begin
                    hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix_s[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= {CNT_W{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            opa_q     <= {(2*WIDTH){1'b0}};
            opb_q     <= {WIDTH{1'b0}};
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: an arithmetic reference model with a
// latency counter is compared against busy/done/hi/lo every cycle, and
// directed operations are pinned to hand-computed results and latencies.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] reg1 = 32'h0;
    logic [31:0] reg2 = 32'h0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .reg1(reg1), .reg2(reg2), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {hi, lo}.
    function automatic logic [63:0] mdu_ref(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        longint             sp;
        sa = a;
        sb = b;
        case (o)
            MDU_MULT: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            MDU_MULTU: return {32'h0, a} * {32'h0, b};
            MDU_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            MDU_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Number of iteration edges an accepted operation takes.
    function automatic int calc_edges(input logic [2:0] o, input logic [31:0] b);
`ifdef MDU_EARLY_TERM_EN
        logic [31:0] m;
        if (o == MDU_DIV || o == MDU_DIVU) return 32;
        m = (o == MDU_MULT && b[31]) ? (~b + 32'h1) : b;
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) return i + 1;
        end
        return 1;
`else
        if (o == MDU_DIV || o == MDU_DIVU || b == 32'h0 || b != 32'h0) return 32;
        return 32;
`endif
    endfunction

    // Reference model state.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic [63:0] m_pend = 64'h0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= 32'h0;
            m_lo   <= 32'h0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                end
                m_left <= m_left - 1;
            end else if (start) begin
                case (op)
                    MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                        m_busy <= 1'b1;
                        m_pend <= mdu_ref(op, reg1, reg2);
                        m_left <= calc_edges(op, reg2) + 1;
                    end
                    MDU_MTHI: m_hi <= reg1;
                    MDU_MTLO: m_lo <= reg1;
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_busy", busy, m_busy);
        check("cyc_done", done, m_done);
        check("cyc_hi", hi, m_hi);
        check("cyc_lo", lo, m_lo);
    end

    // Issue a mul/div, optionally poke a DIV start at CALC edge intr, and
    // check latency (edges counting the accept edge) and final HI/LO.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int ee, input int intr);
        int edges;
        bit seen;
        @(negedge clk); #1;
        start = 1'b1; op = o; reg1 = a; reg2 = b;
        @(posedge clk); #1;
        edges = 1;
        start = 1'b0; reg1 = $urandom; reg2 = $urandom;
        seen = 1'b0;
        while (!seen && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (intr > 0 && edges == intr) begin
                start = 1'b1; op = MDU_DIV; reg1 = 32'h0000_0064; reg2 = 32'h0000_0003;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({name, "_done_seen"}, seen, 1'b1);
        check({name, "_latency"}, edges, ee);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
    endtask

    // Single-edge operation (MTHI/MTLO/undefined): no busy, no done.
    task automatic single(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk); #1;
        start = 1'b1; op = o; reg1 = a; reg2 = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_done"}, done, 1'b0);
    endtask

`ifdef MDU_EARLY_TERM_EN
    localparam int LAT_NEG3X5 = 5;
    localparam int LAT_BUSYHIT = 19;
    localparam int LAT_5X3 = 4;
`else
    localparam int LAT_NEG3X5 = 34;
    localparam int LAT_BUSYHIT = 34;
    localparam int LAT_5X3 = 34;
`endif

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        #1 rst_n = 1'b1;

        run_op("mult_neg3x5", MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT_NEG3X5, 0);
        run_op("multu_max",   MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, 0);
        run_op("div_neg7by2", MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 0);
        run_op("div_ovf",     MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 0);
        run_op("div_negneg",  MDU_DIV,   32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 34, 0);
        run_op("divu_1000_7", MDU_DIVU,  32'h0000_03E8, 32'h0000_0007, 32'h0000_0006, 32'h0000_008E, 34, 0);
        run_op("divu_by0",    MDU_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 34, 0);

        single("mtlo",   MDU_MTLO, 32'h0000_1234, 32'h0000_0064, 32'h0000_1234);
        single("mthi",   MDU_MTHI, 32'hABCD_0000, 32'hABCD_0000, 32'h0000_1234);
        single("undef6", 3'b110,   32'h0000_DEAD, 32'hABCD_0000, 32'h0000_1234);
        single("undef7", 3'b111,   32'h0000_BEEF, 32'hABCD_0000, 32'h0000_1234);

        // -9 * 0x10007 with a DIV start landing on CALC edge 5 (overall edge 6).
        run_op("mult_busyhit", MDU_MULT, 32'hFFFF_FFF7, 32'h0001_0007, 32'hFFFF_FFFF, 32'hFFF6_FFC1, LAT_BUSYHIT, 6);

        // Abort a multiply with reset after CALC edge 10.
        @(negedge clk); #1;
        start = 1'b1; op = MDU_MULT; reg1 = 32'h0000_0003; reg2 = 32'h0010_0000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_op("multu_5x3", MDU_MULTU, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 32'h0000_000F, LAT_5X3, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO register pair.
- It is the writer of HI/LO; the ALU's MFHI/MFLO path is the reader.
- Accepts a one-cycle start with op and two 32-bit operands, iterates, then updates HI/LO and pulses done.
- Sits beside the ALU in EX. The pipeline stalls MFHI/MFLO while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only when busy=0
- op  input  3  operation code (encodings under Decomposition)
- reg1  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
- reg2  input  WIDTH  multiplier / divisor
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when HI/LO have just been written
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, hi=0, lo=0; iteration counter and datapath registers cleared. Reset mid-operation aborts it; no partial result is written.
- State machine has three states:
  - IDLE: start=1 with a MULT/MULTU/DIV/DIVU op -> CALC. At this edge latch operand magnitudes (absolute values for signed ops, raw for unsigned), record result signs, count=0, busy=1.
  - CALC: one iteration per edge. Multiply uses shift-add, 2*WIDTH accumulator. Divide uses restoring shift-subtract. count increments each edge; after WIDTH CALC edges -> FIX.
  - FIX: apply sign correction, write hi/lo, set done=1, busy=0 -> IDLE.
- Latency: accept edge + WIDTH CALC edges + 1 FIX edge. Result is visible after the 34th edge counting the accept edge (WIDTH=32). done is high for exactly the cycle following the FIX edge.
- MTHI/MTLO with start=1 in IDLE: at that edge hi<=reg1 (MTHI) or lo<=reg1 (MTLO). No busy, no done.
- start while busy=1: ignored entirely; op and operands are not sampled.
- start in the same cycle done=1: accepted, since busy is already 0.
- Undefined op codes (110, 111): ignored.
- hi/lo hold their values during CALC; they change only on the FIX edge or on an MTHI/MTLO edge.
- Arithmetic rules:
  - MULT: signed 64-bit product; hi=upper word, lo=lower word.
  - MULTU: the same, unsigned.
  - DIV: quotient truncated toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (reg2=0, DIV or DIVU): full latency still applies; lo=0xFFFFFFFF, hi=reg1 as latched. Not an error, no extra signal.

Optional Feature:
- Macro MDU_EARLY_TERM_EN.
- Defined: multiply CALC exits to FIX on the first CALC edge at which the remaining shifted multiplier magnitude is zero, with a minimum of 1 CALC edge. Divide latency is unchanged.
- Undefined: multiply always uses exactly WIDTH CALC edges.
- Results are bit-identical in both builds. Only done timing differs.

Decomposition:
- Package mdu_pkg holds:
  - op encodings: MDU_MULT=3'b000, MDU_MULTU=3'b001, MDU_DIV=3'b010, MDU_DIVU=3'b011, MDU_MTHI=3'b100, MDU_MTLO=3'b101
  - state encoding: IDLE, CALC, FIX
  - WIDTH default constant
- One natural sub-module, mdu_sign_fix: combinational magnitude/negation helper used at accept (abs) and at FIX (conditional two's-complement negate of the product, quotient and remainder).
- Iteration datapath and FSM stay in mult_div_unit.

Test Plan:
- MULT, reg1=0xFFFFFFFD (-3), reg2=5 -> done after 34 edges; hi=0xFFFFFFFF, lo=0xFFFFFFF1. busy high throughout, done exactly one cycle.
- MULTU, reg1=reg2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV, reg1=0xFFFFFFF9 (-7), reg2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU, reg1=100, reg2=0 -> lo=0xFFFFFFFF, hi=0x00000064. Then MTLO reg1=0x1234 -> lo=0x1234 on the next edge, hi unchanged, no done.
- Start a MULT, assert start with a DIV at CALC edge 5 -> DIV ignored, MULT result correct. Start another MULT, drop rst_n at CALC edge 10 -> hi=lo=0, busy=0 immediately, no done.
- MDU_EARLY_TERM_EN defined, MULTU 5*3 -> done after 2 CALC edges, hi=0, lo=15. Same stimulus undefined -> 32 CALC edges, same result.
